// File: rtl/bg_line_renderer.sv
// Game Boy background line renderer: line/dot timing, per-line tile fetch from VRAM, 1-bpp line commit.
// Optional BG_SIGNED_ADDR_EN adds tileSel for signed (base 0x1000) tile-data addressing.
module bg_line_renderer #(
  parameter int          DOTS_PER_LINE   = 456,
  parameter int          LINES_PER_FRAME = 154,
  parameter int          VISIBLE_LINES   = 144,
  parameter logic [12:0] MAP_BASE        = 13'h1800
) (
  input  logic         pixelClk,
  input  logic         resetN,
  input  logic         enable,
`ifdef BG_SIGNED_ADDR_EN
  input  logic         tileSel,
`endif
  input  logic [7:0]   SCX,
  input  logic [7:0]   SCY,
  input  logic [7:0]   BGP,
  output logic [12:0]  vramAddr,
  input  logic [7:0]   vramData,
  output logic [7:0]   LY,
  output logic [159:0] LineBuffer,
  output logic         lineDone
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LAST_LINE = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);
  localparam logic [4:0] LAST_TILE = 5'd20;

  typedef enum logic [2:0] {S_IDLE, S_MAP, S_LO, S_HI, S_PUSH, S_DONE} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [8:0]     r_dot;
  logic [7:0]     r_line;
  logic [4:0]     r_tile;
  logic [7:0]     r_row;
  logic [7:0]     r_scx;
  logic [7:0]     r_lo;
  logic [12:0]    r_addr;
  logic [159:0]   r_shadow;
  logic [12:0]    w_addr;
  logic [12:0]    w_tileBase;
  logic [4:0]     w_col;
  logic           w_lastDot;
  logic           w_lineStart;
  logic [8:0]     w_pixPos  [8];
  logic [8:0]     w_pixDiff [8];
  logic [7:0]     w_pixVis;
  logic [7:0]     w_pixBit;

  assign w_lastDot   = (r_dot == LAST_DOT);
  assign w_lineStart = (r_dot == 9'd0) && (r_line < VIS_LINES);
  assign w_col       = r_scx[7:3] + r_tile;

`ifdef BG_SIGNED_ADDR_EN
  assign w_tileBase = tileSel ? {1'b0, vramData, 4'b0000}
                              : 13'h1000 + {vramData[7], vramData, 4'b0000};
`else
  assign w_tileBase = {1'b0, vramData, 4'b0000};
`endif

  always_ff @(posedge pixelClk) begin
    if (!resetN || !enable) begin
      r_dot  <= 9'd0;
      r_line <= 8'd0;
    end else if (w_lastDot) begin
      r_dot  <= 9'd0;
      r_line <= (r_line == LAST_LINE) ? 8'd0 : r_line + 8'd1;
    end else begin
      r_dot <= r_dot + 9'd1;
    end
  end

  always_ff @(posedge pixelClk) begin
    if (!resetN || !enable) r_state <= S_IDLE;
    else                    r_state <= w_nextState;
  end

  // vramAddr is combinational during MAP/LO/HI so the data arrives in the next state;
  // LO uses the tile number on vramData directly, other states replay the last address.
  always_comb begin
    w_nextState = r_state;
    w_addr      = r_addr;
    case (r_state)
      S_IDLE: if (w_lineStart) w_nextState = S_MAP;
      S_MAP: begin
        w_addr      = MAP_BASE + {3'b000, r_row[7:3], w_col};
        w_nextState = S_LO;
      end
      S_LO: begin
        w_addr      = w_tileBase + {9'b0, r_row[2:0], 1'b0};
        w_nextState = S_HI;
      end
      S_HI: begin
        w_addr      = r_addr + 13'd1;
        w_nextState = S_PUSH;
      end
      S_PUSH: w_nextState = (r_tile == LAST_TILE) ? S_DONE : S_MAP;
      S_DONE: if (w_lastDot) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    vramAddr = w_addr;
  end

  // Screen x of each pixel in the tile being pushed, after removing the fine scroll.
  always_comb begin
    for (int p = 0; p < 8; p++) begin
      w_pixPos[p]  = {1'b0, r_tile, 3'b000} + 9'(p);
      w_pixDiff[p] = w_pixPos[p] - {6'b0, r_scx[2:0]};
      w_pixVis[p]  = (w_pixPos[p] >= {6'b0, r_scx[2:0]}) && (w_pixDiff[p] < 9'd160);
      w_pixBit[p]  = BGP[{vramData[7-p], r_lo[7-p], 1'b1}];
    end
  end

  always_ff @(posedge pixelClk) begin
    if (!resetN || !enable) begin
      r_tile   <= 5'd0;
      r_row    <= 8'd0;
      r_scx    <= 8'd0;
      r_lo     <= 8'd0;
      r_addr   <= 13'd0;
      r_shadow <= '0;
    end else begin
      r_addr <= w_addr;
      if (r_state == S_IDLE && w_lineStart) begin
        r_scx  <= SCX;
        r_row  <= r_line + SCY;
        r_tile <= 5'd0;
      end
      if (r_state == S_HI) r_lo <= vramData;
      if (r_state == S_PUSH) begin
        r_tile <= r_tile + 5'd1;
        for (int p = 0; p < 8; p++) begin
          if (w_pixVis[p]) r_shadow[w_pixDiff[p][7:0]] <= w_pixBit[p];
        end
      end
    end
  end

  // LY and LineBuffer change on the same edge so the scan-out side never sees a torn line.
  always_ff @(posedge pixelClk) begin
    if (!resetN) begin
      LY         <= 8'd0;
      LineBuffer <= '0;
      lineDone   <= 1'b0;
    end else if (!enable) begin
      LY       <= 8'd0;
      lineDone <= 1'b0;
    end else begin
      lineDone <= w_lastDot;
      if (w_lastDot) begin
        LY <= r_line;
        if (r_line < VIS_LINES) LineBuffer <= r_shadow;
      end
    end
  end

endmodule

// File: tb/tb_bg_line_renderer.sv
// Directed bench for bg_line_renderer: VRAM model, pixel-space reference renderer and a commit scoreboard.
module tb_bg_line_renderer;

  logic         pixelClk = 1'b0;
  logic         resetN   = 1'b0;
  logic         enable   = 1'b0;
  logic         tileSel  = 1'b1;
  logic [7:0]   SCX      = 8'd0;
  logic [7:0]   SCY      = 8'd0;
  logic [7:0]   BGP      = 8'hE4;
  logic [12:0]  vramAddr;
  logic [7:0]   vramData;
  logic [7:0]   LY;
  logic [159:0] LineBuffer;
  logic         lineDone;

  logic [7:0]   vram [8192];
  int           total = 0;
  int           bad   = 0;
  logic [159:0] heldLb = '0;

  typedef struct {
    logic [7:0]   ly;
    logic [159:0] lb;
  } exp_t;
  exp_t sb [$];

  bg_line_renderer dut (
    .pixelClk   (pixelClk),
    .resetN     (resetN),
    .enable     (enable),
`ifdef BG_SIGNED_ADDR_EN
    .tileSel    (tileSel),
`endif
    .SCX        (SCX),
    .SCY        (SCY),
    .BGP        (BGP),
    .vramAddr   (vramAddr),
    .vramData   (vramData),
    .LY         (LY),
    .LineBuffer (LineBuffer),
    .lineDone   (lineDone)
  );

  always #5 pixelClk = ~pixelClk;

  // Synchronous-read VRAM: data for an address shows up one cycle later.
  always @(posedge pixelClk) vramData <= vram[vramAddr];

  // Renders in screen space: each output pixel looks up its own map entry and tile row.
  function automatic logic [159:0] modelLine(input int line, input logic [7:0] scx,
                                             input logic [7:0] scy, input logic [7:0] bgp,
                                             input logic tsel);
    logic [159:0] lb;
    int row, px, mapAddr, tileNum, base, addr, b, c;
    lb  = '0;
    row = (line + int'(scy)) % 256;
    for (int x = 0; x < 160; x++) begin
      px      = (x + int'(scx)) % 256;
      mapAddr = 'h1800 + (row / 8) * 32 + px / 8;
      tileNum = int'(vram[mapAddr]);
      if (tsel) base = tileNum * 16;
      else      base = (4096 + ((tileNum >= 128) ? tileNum - 256 : tileNum) * 16) & 8191;
      addr    = base + (row % 8) * 2;
      b       = 7 - (px % 8);
      c       = 2 * int'(vram[addr + 1][b]) + int'(vram[addr][b]);
      lb[x]   = bgp[2 * c + 1];
    end
    return lb;
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] scx, input logic [7:0] scy,
                               input logic [7:0] bgp, input logic tsel);
    SCX     = scx;
    SCY     = scy;
    BGP     = bgp;
    tileSel = tsel;
  endtask

  task automatic resetDut();
    @(negedge pixelClk);
    resetN = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge pixelClk);
    resetN = 1'b1;
    enable = 1'b1;
    heldLb = '0;
    sb.delete();
  endtask

  task automatic expectLine(input int n);
    exp_t e;
    e.ly = 8'(n);
    if (n < 144) begin
      e.lb   = modelLine(n, SCX, SCY, BGP, tileSel);
      heldLb = e.lb;
    end else begin
      e.lb = heldLb;
    end
    sb.push_back(e);
  endtask

  task automatic waitCommit(input int expCycles);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      @(negedge pixelClk);
      cyc++;
    end while (lineDone !== 1'b1 && cyc < expCycles + 50);
    total++;
    assert (lineDone === 1'b1)
    else begin
      bad++;
      $error("[TB] FAIL commitWait: lineDone=%0b expected=1 within %0d cycles", lineDone, expCycles + 50);
    end
    checkOutput("commitCycles", 160'(cyc), 160'(expCycles));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("LY[%0d]", e.ly), 160'(LY), 160'(e.ly));
      checkOutput($sformatf("LineBuffer[%0d]", e.ly), LineBuffer, e.lb);
    end
  endtask

  initial begin
    int expCyc;
    for (int a = 0; a < 8192; a++) vram[a] = 8'h00;

    // Full frame with blank VRAM; SCY=250 makes line 10 fetch from row 4 of map row 0.
    applyStimulus(8'd0, 8'd250, 8'hE4, 1'b1);
    resetDut();
    checkOutput("resetLY", 160'(LY), 160'd0);
    checkOutput("resetLineBuffer", LineBuffer, '0);
    checkOutput("resetVramAddr", 160'(vramAddr), 160'd0);
    for (int n = 0; n < 155; n++) begin
      expCyc = (n == 0) ? 456 : (n == 1) ? 455 : (n == 10) ? 451 : 456;
      expectLine(n % 154);
      waitCommit(expCyc);
      if (n == 0) begin
        @(negedge pixelClk);
        checkOutput("pulseWidth", 160'(lineDone), 160'd0);
      end
      if (n == 9) begin
        @(negedge pixelClk);
        checkOutput("l10MapAddr0", 160'(vramAddr), 160'h1800);
        @(negedge pixelClk);
        checkOutput("l10LoAddr", 160'(vramAddr), 160'h0008);
        @(negedge pixelClk);
        checkOutput("l10HiAddr", 160'(vramAddr), 160'h0009);
        repeat (2) @(negedge pixelClk);
        checkOutput("l10MapAddr1", 160'(vramAddr), 160'h1801);
      end
    end

    // Map entry 0 = tile 1, tile 1 row 0 is colour 1 everywhere.
    vram['h1800] = 8'h01;
    vram[16]     = 8'hFF;
    vram[17]     = 8'h00;
    applyStimulus(8'd0, 8'd0, 8'hE4, 1'b1);
    resetDut();
    @(negedge pixelClk);
    checkOutput("mapAddr", 160'(vramAddr), 160'h1800);
    @(negedge pixelClk);
    checkOutput("loAddr", 160'(vramAddr), 160'h0010);
    @(negedge pixelClk);
    checkOutput("hiAddr", 160'(vramAddr), 160'h0011);
    expectLine(0);
    waitCommit(453);
    checkOutput("bgpE4Low", 160'(LineBuffer[7:0]), 160'h00);

    applyStimulus(8'd0, 8'd0, 8'hFC, 1'b1);
    resetDut();
    expectLine(0);
    waitCommit(456);
    checkOutput("bgpFCLow", 160'(LineBuffer[7:0]), 160'hFF);
    checkOutput("bgpFCHigh", 160'(LineBuffer[159:8]), 160'h0);

    // Fine scroll: column 0 falls off the left, column 1 pixel 0 lands on x=5.
    vram['h1800] = 8'h00;
    vram['h1801] = 8'h01;
    for (int r = 0; r < 8; r++) begin
      vram[16 + 2 * r] = 8'h80;
      vram[17 + 2 * r] = 8'h80;
    end
    applyStimulus(8'd3, 8'd0, 8'hE4, 1'b1);
    resetDut();
    expectLine(0);
    waitCommit(456);
    checkOutput("scx3Bit5", LineBuffer, 160'h20);

    // Reset in the middle of line 5's fetch window.
    repeat (4 * 456 + 40) @(negedge pixelClk);
    checkOutput("preResetLY", 160'(LY), 160'd4);
    checkOutput("preResetLB", LineBuffer, modelLine(4, SCX, SCY, BGP, tileSel));
    resetN = 1'b0;
    @(negedge pixelClk);
    checkOutput("midResetLY", 160'(LY), 160'd0);
    checkOutput("midResetLB", LineBuffer, '0);
    checkOutput("midResetDone", 160'(lineDone), 160'd0);
    checkOutput("midResetAddr", 160'(vramAddr), 160'd0);
    resetN = 1'b1;
    heldLb = '0;
    expectLine(0);
    waitCommit(456);

    // Dropping enable parks timing but keeps the last committed line.
    expectLine(1);
    waitCommit(456);
    repeat (10) @(negedge pixelClk);
    enable = 1'b0;
    @(negedge pixelClk);
    checkOutput("disLY", 160'(LY), 160'd0);
    checkOutput("disLB", LineBuffer, modelLine(1, SCX, SCY, BGP, tileSel));
    checkOutput("disAddr", 160'(vramAddr), 160'd0);
    checkOutput("disDone", 160'(lineDone), 160'd0);
    enable = 1'b1;
    expectLine(0);
    waitCommit(456);

`ifdef BG_SIGNED_ADDR_EN
    vram['h1800] = 8'hFF;
    vram['h0FF0] = 8'hF0;
    vram['h0FF1] = 8'h0F;
    applyStimulus(8'd0, 8'd0, 8'hE4, 1'b0);
    resetDut();
    @(negedge pixelClk);
    checkOutput("sgnMapAddr", 160'(vramAddr), 160'h1800);
    @(negedge pixelClk);
    checkOutput("sgnLoAddr", 160'(vramAddr), 160'h0FF0);
    @(negedge pixelClk);
    checkOutput("sgnHiAddr", 160'(vramAddr), 160'h0FF1);
    expectLine(0);
    waitCommit(453);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
